// File: rtl/csa_block.sv
// Carry-select adder slice for the FIR datapath.
// Combinational sum plus a registered copy with async reset.
module csa_ripple #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c,
  output logic [W-1:0] s,
  output logic         co
);
  logic [W:0] cc;

  always_comb begin
    cc    = '0;
    s     = '0;
    cc[0] = c;
    for (int i = 0; i < W; i++) begin
      s[i]    = a[i] ^ b[i] ^ cc[i];
      cc[i+1] = (a[i] & b[i])
              | (cc[i] & (a[i] ^ b[i]));
    end
  end

  assign co = cc[W];
endmodule

module csa_block #(
  parameter int IN_DATAWIDTH  = 2,
  parameter int OUT_DATAWIDTH = IN_DATAWIDTH + 1,
  parameter int BLOCK_WIDTH   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IN_DATAWIDTH-1:0]  in1,
  input  logic [IN_DATAWIDTH-1:0]  in2,
  input  logic                     cin,
  output logic [OUT_DATAWIDTH-1:0] sum,
  output logic [OUT_DATAWIDTH-1:0] sum_q
);
  localparam int NG =
    (IN_DATAWIDTH + BLOCK_WIDTH - 1) / BLOCK_WIDTH;

  logic [IN_DATAWIDTH-1:0] sbits;
  logic [NG-1:0]           c0v;
  logic [NG-1:0]           c1v;
  logic [NG:0]             carry;

  for (genvar g = 0; g < NG; g++) begin : grp
    localparam int LO = g * BLOCK_WIDTH;
    localparam int W  =
      (IN_DATAWIDTH - LO < BLOCK_WIDTH) ?
      (IN_DATAWIDTH - LO) : BLOCK_WIDTH;

    if (g == 0) begin : first
      logic co;
      csa_ripple #(.W(W)) u_add (
        .a  (in1[LO +: W]),
        .b  (in2[LO +: W]),
        .c  (cin),
        .s  (sbits[LO +: W]),
        .co (co)
      );
      assign c0v[g] = co;
      assign c1v[g] = co;
    end else begin : sel
      logic [W-1:0] s0;
      logic [W-1:0] s1;
      csa_ripple #(.W(W)) u_add0 (
        .a  (in1[LO +: W]),
        .b  (in2[LO +: W]),
        .c  (1'b0),
        .s  (s0),
        .co (c0v[g])
      );
      csa_ripple #(.W(W)) u_add1 (
        .a  (in1[LO +: W]),
        .b  (in2[LO +: W]),
        .c  (1'b1),
        .s  (s1),
        .co (c1v[g])
      );
      assign sbits[LO +: W] = carry[g] ? s1 : s0;
    end
  end

  // Carry select chain kept in one process so
  // the per-group carry never loops through a net.
  always_comb begin
    carry    = '0;
    carry[0] = cin;
    for (int g = 0; g < NG; g++)
      carry[g+1] = carry[g] ? c1v[g] : c0v[g];
  end

  assign sum = OUT_DATAWIDTH'({carry[NG], sbits});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sum_q <= '0;
    else        sum_q <= sum;
  end
endmodule

// File: tb/tb_csa_block.sv
// Random and directed checks of csa_block
// against a plain integer-addition reference.
module tb_csa_block;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] a0, b0;
  logic       ci0;
  logic [2:0] s0, q0;

  logic [7:0] a1, b1, a2, b2, a3, b3;
  logic       ci1, ci2, ci3;
  logic [8:0] s1, q1, s2, q2, s3, q3;

  csa_block u_d0 (
    .clk(clk), .rst_n(rst_n),
    .in1(a0), .in2(b0), .cin(ci0),
    .sum(s0), .sum_q(q0)
  );

  csa_block #(.IN_DATAWIDTH(8), .BLOCK_WIDTH(3)) u_d1 (
    .clk(clk), .rst_n(rst_n),
    .in1(a1), .in2(b1), .cin(ci1),
    .sum(s1), .sum_q(q1)
  );

  csa_block #(.IN_DATAWIDTH(8), .BLOCK_WIDTH(8)) u_d2 (
    .clk(clk), .rst_n(rst_n),
    .in1(a2), .in2(b2), .cin(ci2),
    .sum(s2), .sum_q(q2)
  );

  csa_block #(.IN_DATAWIDTH(8), .BLOCK_WIDTH(5)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .in1(a3), .in2(b3), .cin(ci3),
    .sum(s3), .sum_q(q3)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int ref_add(
    input int x, input int y, input int c
  );
    return x + y + c;
  endfunction

  int e0, e1;

  initial begin
    a0 = '0; b0 = '0; ci0 = 1'b0;
    a1 = '0; b1 = '0; ci1 = 1'b0;
    a2 = '0; b2 = '0; ci2 = 1'b0;
    a3 = '0; b3 = '0; ci3 = 1'b0;

    #1;
    check("reset_q0", 32'(q0), 0);
    check("reset_q1", 32'(q1), 0);
    a0 = 2'd3; b0 = 2'd2; ci0 = 1'b0;
    #1;
    check("sum_in_reset", 32'(s0), 5);
    @(posedge clk); #1;
    check("q_held_reset", 32'(q0), 0);

    for (int i = 0; i < 4; i++) begin
      a0 = 2'(i); b0 = 2'(i); ci0 = 1'b1;
      #1;
      check($sformatf("sweep_%0d", i),
            32'(s0), 2 * i + 1);
    end

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++) begin
          a0 = 2'(x); b0 = 2'(y); ci0 = 1'(c);
          #1;
          check($sformatf("exh_%0d_%0d_%0d", x, y, c),
                32'(s0), ref_add(x, y, c));
        end

    @(negedge clk);
    rst_n = 1'b1;
    a0 = '0; b0 = '0; ci0 = 1'b0;
    @(posedge clk); #1;
    check("reg_zero", 32'(q0), 0);
    @(negedge clk);
    a0 = 2'd3; b0 = 2'd3; ci0 = 1'b1;
    #1;
    check("reg_hold", 32'(q0), 0);
    @(posedge clk); #1;
    check("reg_7", 32'(q0), 7);

    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("async_q", 32'(q0), 0);
    check("async_sum", 32'(s0), 7);
    @(posedge clk); #1;
    check("async_hold", 32'(q0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("async_still0", 32'(q0), 0);
    @(posedge clk); #1;
    check("async_recover", 32'(q0), 7);

    a1 = 8'd255; b1 = 8'd255; ci1 = 1'b1;
    a2 = 8'd128; b2 = 8'd128; ci2 = 1'b0;
    a3 = 8'd255; b3 = 8'd255; ci3 = 1'b1;
    #1;
    check("bw3_max", 32'(s1), 511);
    check("bw8_128", 32'(s2), 256);
    check("bw5_max", 32'(s3), 511);
    a1 = 8'd0; b1 = 8'd0; ci1 = 1'b0;
    #1;
    check("bw3_zero", 32'(s1), 0);

    for (int k = 0; k < 1000; k++) begin
      a1 = 8'($urandom); b1 = 8'($urandom);
      ci1 = 1'($urandom);
      a2 = 8'($urandom); b2 = 8'($urandom);
      ci2 = 1'($urandom);
      a3 = 8'($urandom); b3 = 8'($urandom);
      ci3 = 1'($urandom);
      #1;
      check("rnd_bw3", 32'(s1),
            ref_add(int'(a1), int'(b1), int'(ci1)));
      check("rnd_bw8", 32'(s2),
            ref_add(int'(a2), int'(b2), int'(ci2)));
      check("rnd_bw5", 32'(s3),
            ref_add(int'(a3), int'(b3), int'(ci3)));
    end

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      a0 = 2'($urandom); b0 = 2'($urandom);
      ci0 = 1'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      ci1 = 1'($urandom);
      e0 = ref_add(int'(a0), int'(b0), int'(ci0));
      e1 = ref_add(int'(a1), int'(b1), int'(ci1));
      @(posedge clk); #1;
      check("b2b_q0", 32'(q0), e0);
      check("b2b_q1", 32'(q1), e1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
